vde_trail_unwinder: RTL

VDE_TRAIL_UNWINDER -- requirements
Module: vde_trail_unwinder

---
 rtl/vde_trail_unwinder.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/vde_trail_unwinder.sv
// Assignment trail LIFO with level-tagged entries; unwinds to a target level, one clear per cycle.
// Optional macro VDE_TRAIL_PHASE_SAVE_EN stores each entry's polarity and replays it on clear_phase.
module vde_trail_unwinder #(
  parameter int MAX_VARS = 256,
  parameter int LEVEL_W  = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          flush,
  input  logic                          push_valid,
  input  logic [31:0]                   push_var,
  input  logic                          push_value,
  input  logic                          push_is_decision,
  output logic                          push_ready,
  input  logic                          backtrack_req,
  input  logic [LEVEL_W-1:0]            backtrack_level,
  output logic                          backtrack_done,
  output logic                          clear_valid,
  output logic [31:0]                   clear_var,
  output logic                          clear_phase,
  output logic [LEVEL_W-1:0]            cur_level,
  output logic [$clog2(MAX_VARS+1)-1:0] trail_count,
  output logic                          overflow
);
  localparam int CW = $clog2(MAX_VARS + 1);
  localparam int IW = (MAX_VARS > 1) ? $clog2(MAX_VARS) : 1;

  typedef enum logic [1:0] {IDLE, UNWIND, DONE} state_e;

  state_e             state_q;
  logic [CW-1:0]      cnt_q;
  logic [LEVEL_W-1:0] lvl_q, tgt_q;
  logic               ovf_q, clr_v_q, done_q;
  logic [31:0]        clr_var_q;

  logic [31:0]        var_mem [MAX_VARS];
  logic [LEVEL_W-1:0] lvl_mem [MAX_VARS];
`ifdef VDE_TRAIL_PHASE_SAVE_EN
  logic               val_mem [MAX_VARS];
  logic               clr_ph_q;
`endif

  logic               push_acc, push_wr, pop;
  logic [LEVEL_W-1:0] push_lvl, eff_lvl, cmp_tgt, tp_lvl;
  logic [CW-1:0]      eff_cnt;
  logic [IW-1:0]      top_idx;
  logic [31:0]        tp_var;
  logic               tp_val;

  always_comb begin
    push_acc = push_valid && (state_q == IDLE) && !flush;
    push_wr  = push_acc && (cnt_q != CW'(MAX_VARS));
    push_lvl = push_is_decision ? lvl_q + LEVEL_W'(1) : lvl_q;
    eff_lvl  = push_wr ? push_lvl : lvl_q;
    eff_cnt  = push_wr ? cnt_q + CW'(1) : cnt_q;
    top_idx  = IW'(cnt_q - CW'(1));
    cmp_tgt  = (state_q == IDLE) ? backtrack_level : tgt_q;
    // A same-cycle push sits above the stored trail, so it is the first candidate to pop.
    if ((state_q == IDLE) && push_wr) begin
      tp_var = push_var;
      tp_lvl = push_lvl;
      tp_val = push_value;
    end else begin
      tp_var = var_mem[top_idx];
      tp_lvl = lvl_mem[top_idx];
`ifdef VDE_TRAIL_PHASE_SAVE_EN
      tp_val = val_mem[top_idx];
`else
      tp_val = 1'b0;
`endif
    end
    pop = (((state_q == IDLE) ? eff_cnt : cnt_q) != '0) && (tp_lvl > cmp_tgt);
  end

  always_ff @(posedge clk) begin
    if (push_wr) begin
      var_mem[cnt_q[IW-1:0]] <= push_var;
      lvl_mem[cnt_q[IW-1:0]] <= push_lvl;
`ifdef VDE_TRAIL_PHASE_SAVE_EN
      val_mem[cnt_q[IW-1:0]] <= push_value;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      lvl_q     <= '0;
      tgt_q     <= '0;
      ovf_q     <= 1'b0;
      clr_v_q   <= 1'b0;
      clr_var_q <= '0;
      done_q    <= 1'b0;
`ifdef VDE_TRAIL_PHASE_SAVE_EN
      clr_ph_q  <= 1'b0;
`endif
    end else if (flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      lvl_q   <= '0;
      ovf_q   <= 1'b0;
      clr_v_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          clr_v_q <= 1'b0;
          done_q  <= 1'b0;
          if (push_acc) begin
            if (push_wr) begin
              cnt_q <= eff_cnt;
              lvl_q <= push_lvl;
            end else begin
              ovf_q <= 1'b1;
            end
          end
          if (backtrack_req) begin
            if (backtrack_level >= eff_lvl) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else if (pop) begin
              tgt_q     <= backtrack_level;
              cnt_q     <= eff_cnt - CW'(1);
              clr_v_q   <= 1'b1;
              clr_var_q <= tp_var;
`ifdef VDE_TRAIL_PHASE_SAVE_EN
              clr_ph_q  <= tp_val;
`endif
              state_q   <= UNWIND;
            end else begin
              lvl_q   <= backtrack_level;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        UNWIND: begin
          if (pop) begin
            cnt_q     <= cnt_q - CW'(1);
            clr_v_q   <= 1'b1;
            clr_var_q <= tp_var;
`ifdef VDE_TRAIL_PHASE_SAVE_EN
            clr_ph_q  <= tp_val;
`endif
          end else begin
            clr_v_q <= 1'b0;
            lvl_q   <= tgt_q;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        default: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign push_ready     = (state_q == IDLE);
  assign backtrack_done = done_q;
  assign clear_valid    = clr_v_q;
  assign clear_var      = clr_var_q;
`ifdef VDE_TRAIL_PHASE_SAVE_EN
  assign clear_phase    = clr_ph_q;
`else
  assign clear_phase    = 1'b0;
`endif
  assign cur_level      = lvl_q;
  assign trail_count    = cnt_q;
  assign overflow       = ovf_q;

  logic unused_tp_val;
  assign unused_tp_val = tp_val;
endmodule
